texto_ctrl: RTL and testbench
=============================

# texto_ctrl

Controller that sequences the character-rendering datapath of the VGA text overlay. From the pixel coordinates it derives the character slot and glyph row, and issues the font-ROM address. It pipelines the column and window flags to match the ROM latency and produces the final overlay pixel. It owns a 4-character message that is double-buffered: host writes land in a shadow copy, which is committed to the displayed copy only at frame start, so the text never tears mid-frame.

## Interface
- X0, 300, left pixel column of the text window
- Y0, 230, top pixel row of the text window
- RESET_CODE, 7'h20, character code loaded into all slots (shadow and active) on reset
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- pixel_tick  in  1  one-clk strobe per pixel (1 in 4 clk); pixel_x/pixel_y/video_on are sampled only when high
- video_on  in  1  active-video flag from the sync generator
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- msg_we  in  1  shadow-message write strobe
- msg_idx  in  2  slot index for msg_we
- msg_code  in  7  character code for msg_we
- rom_data  in  8  font-ROM row bitmap; bit 7 = leftmost pixel; valid 1 clk after rom_addr
- rom_addr  out  12  {code[6:0], row[4:0]} to the font ROM
- char  out  2  character slot under the current pixel
- rowad  out  6  glyph row under the current pixel, 0..31 (bit 5 always 0)
- pix_valid  out  1  strobe marking a valid pix_on sample
- pix_on  out  1  overlay pixel (1 = foreground)
- dirty  out  1  shadow differs from active (write pending commit)

## Operation
- Window: 4 cells of 8x32 px. in_win = X0 <= x < X0+32 and Y0 <= y < Y0+32 and video_on.
  - dx = x - X0 and dy = y - Y0, computed in 10 bits.
  - char = dx[4:3], col = dx[2:0], rowad = {1'b0, dy[4:0]}.
- Stage 1 (clk after a sampled tick):
  - If in_win: register char, rowad, col, and rom_addr = {active[char], dy[4:0]}, and set in_win_d = 1.
  - Else: char = 0, rowad = 0, rom_addr = 0, in_win_d = 0.
  - Set tick_d1 = 1.
- Stage 2: ROM presents rom_data. Delay col, in_win_d and tick_d1 by one clk.
- Stage 3:
  - pix_valid = tick_d2.
  - pix_on = in_win_d2 & rom_data[7 - col_d2], registered.
  - Outside a tick pipeline slot, pix_valid = 0 and pix_on holds its last value.
- Message:
  - msg_we writes shadow[msg_idx] = msg_code and sets dirty = 1.
  - Commit condition: pixel_tick with pixel_x == 0 and pixel_y == 0.
  - On commit, if dirty: active = shadow and dirty = 0.
- Simultaneous msg_we and commit in the same clk:
  - Commit copies the pre-write shadow.
  - The write then lands in shadow and dirty ends at 1.
  - The new code is displayed next frame.
- Writes to the same slot before a commit: last write wins.
- Active changes only at commit, never mid-frame.

## Timing
- Reset (async, immediate): rom_addr = 0, char = 0, rowad = 0, pix_valid = 0, pix_on = 0, dirty = 0; all pipeline flags 0; shadow and active = RESET_CODE in every slot.
- Reset mid-frame discards in-flight pipeline samples; no pix_valid is produced for them.
- Latency:
  - Tick sampled at clk edge N.
  - char, rowad and rom_addr valid after edge N+1.
  - pix_valid/pix_on valid after edge N+3.
  - pix_valid is high for exactly 1 clk.
- The tick spacing of 4 clk is at least the pipeline depth; the pipeline never holds two ticks in one stage.
- Boundary conditions:
  - x = X0+31 is char 3, col 7.
  - x = X0+32 is outside the window.
  - y = Y0+31 is rowad 31.
  - y = Y0+32 is outside the window.
  - pixel_x < X0 is outside the window; there is no wrap from the 10-bit subtraction, because the range test runs before dx is used.
- video_on = 0 inside the window coordinates forces pix_on = 0, with pix_valid still pulsed.
- Commit takes effect from edge N+1. A commit tick at (0,0) lies outside the window, so the first in-window pixel of the frame uses the new text.

## Test plan
- Reset: assert rst mid-operation -> all outputs 0 immediately, dirty = 0, every slot reads 7'h20 via rom_addr at the next in-window tick (x=300, y=230 -> rom_addr = 12'h400).
- Write slot 0 = 7'h41, then commit tick at (0,0), then tick at x=300, y=230 -> 1 clk later rom_addr = 12'h820, char = 0, rowad = 0. Drive rom_data = 8'h80 -> 3 clk after the tick, pix_valid = 1 and pix_on = 1.
- Tick at x=331, y=261 with rom_data = 8'h01 -> char = 3, rowad = 31, pix_on = 1. Tick at x=332 -> char = 0, rowad = 0, pix_on = 0, pix_valid = 1.
- Write slot 2 = 7'h42 mid-frame, without commit -> dirty = 1; rom_addr for char 2 still uses the old code until the (0,0) tick, then uses 7'h42 and dirty = 0.
- msg_we (slot 1 = 7'h43) in the same clk as the commit tick -> active[1] unchanged and dirty = 1; the next commit applies 7'h43.
- video_on = 0 at x=310, y=240 with rom_data = 8'hFF -> pix_valid = 1 and pix_on = 0; ticks with x = 299 or y = 229 -> pix_on = 0.

Source files
------------

// File: rtl/texto_ctrl.sv
// VGA text-overlay controller: window decode, font-ROM addressing,
// pixel pipeline and a double-buffered 4-character message.
module texto_ctrl #(
    parameter int         X0         = 300,
    parameter int         Y0         = 230,
    parameter logic [6:0] RESET_CODE = 7'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        msg_we,
    input  logic [1:0]  msg_idx,
    input  logic [6:0]  msg_code,
    input  logic [7:0]  rom_data,
    output logic [11:0] rom_addr,
    output logic [1:0]  char,
    output logic [5:0]  rowad,
    output logic        pix_valid,
    output logic        pix_on,
    output logic        dirty
);

    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + 32);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + 32);

    logic [6:0]  shadow_q [4];
    logic [6:0]  active_q [4];
    logic        dirty_q;

    logic [11:0] rom_addr_q;
    logic [1:0]  char_q;
    logic [5:0]  rowad_q;
    logic [2:0]  col1_q, col2_q;
    logic        win1_q, win2_q;
    logic        tick1_q, tick2_q;
    logic        pix_valid_q, pix_on_q;

    logic        in_win;
    logic        commit;
    logic [4:0]  dx, dy;

    // Range test is done on the full coordinates, so the low-bit offsets
    // below are only ever used for pixels already known to be in the window.
    assign in_win = video_on
                 && (pixel_x >= XL) && (pixel_x < XH)
                 && (pixel_y >= YL) && (pixel_y < YH);
    assign dx     = pixel_x[4:0] - XL[4:0];
    assign dy     = pixel_y[4:0] - YL[4:0];
    assign commit = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q  <= '0;
            char_q      <= '0;
            rowad_q     <= '0;
            col1_q      <= '0;
            col2_q      <= '0;
            win1_q      <= 1'b0;
            win2_q      <= 1'b0;
            tick1_q     <= 1'b0;
            tick2_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_on_q    <= 1'b0;
        end else begin
            tick1_q <= pixel_tick;
            if (pixel_tick) begin
                if (in_win) begin
                    char_q     <= dx[4:3];
                    col1_q     <= dx[2:0];
                    rowad_q    <= {1'b0, dy};
                    rom_addr_q <= {active_q[dx[4:3]], dy};
                    win1_q     <= 1'b1;
                end else begin
                    char_q     <= '0;
                    col1_q     <= '0;
                    rowad_q    <= '0;
                    rom_addr_q <= '0;
                    win1_q     <= 1'b0;
                end
            end
            tick2_q     <= tick1_q;
            col2_q      <= col1_q;
            win2_q      <= win1_q;
            pix_valid_q <= tick2_q;
            if (tick2_q)
                pix_on_q <= win2_q & rom_data[3'd7 - col2_q];
        end
    end

    // A write in the commit clock lands after the copy, so it stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= RESET_CODE;
                active_q[i] <= RESET_CODE;
            end
        end else begin
            if (commit && dirty_q) begin
                for (int i = 0; i < 4; i++)
                    active_q[i] <= shadow_q[i];
                dirty_q <= 1'b0;
            end
            if (msg_we) begin
                shadow_q[msg_idx] <= msg_code;
                dirty_q           <= 1'b1;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign char      = char_q;
    assign rowad     = rowad_q;
    assign pix_valid = pix_valid_q;
    assign pix_on    = pix_on_q;
    assign dirty     = dirty_q;

endmodule

// File: tb/tb_texto_ctrl.sv
// Directed testbench for texto_ctrl: window decode, pipeline timing,
// message double-buffering and reset behaviour.
module tb_texto_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        msg_we;
    logic [1:0]  msg_idx;
    logic [6:0]  msg_code;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic [1:0]  char;
    logic [5:0]  rowad;
    logic        pix_valid;
    logic        pix_on;
    logic        dirty;

    int n_checks = 0;
    int n_errors = 0;

    texto_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (pixel_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .msg_we     (msg_we),
        .msg_idx    (msg_idx),
        .msg_code   (msg_code),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .char       (char),
        .rowad      (rowad),
        .pix_valid  (pix_valid),
        .pix_on     (pix_on),
        .dirty      (dirty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel tick followed by three idle clocks; checks stage-1 outputs
    // one clock later and the single pix_valid pulse three clocks later.
    task automatic do_tick(input string tag, input int x, input int y,
                           input logic von, input logic [11:0] e_addr,
                           input logic [1:0] e_char, input logic [5:0] e_row,
                           input logic e_on);
        @(negedge clk);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        video_on   = von;
        pixel_tick = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        check({tag, " rom_addr"}, 32'(rom_addr), 32'(e_addr));
        check({tag, " char"}, 32'(char), 32'(e_char));
        check({tag, " rowad"}, 32'(rowad), 32'(e_row));
        @(negedge clk);
        check({tag, " valid_early"}, 32'(pix_valid), 32'd0);
        @(negedge clk);
        check({tag, " pix_valid"}, 32'(pix_valid), 32'd1);
        check({tag, " pix_on"}, 32'(pix_on), 32'(e_on));
        @(negedge clk);
        check({tag, " valid_late"}, 32'(pix_valid), 32'd0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [6:0] code);
        @(negedge clk);
        msg_we   = 1'b1;
        msg_idx  = idx;
        msg_code = code;
        @(negedge clk);
        msg_we = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pixel_tick = 1'b0;
        video_on   = 1'b1;
        pixel_x    = '0;
        pixel_y    = '0;
        msg_we     = 1'b0;
        msg_idx    = '0;
        msg_code   = '0;
        rom_data   = 8'h80;
        repeat (2) @(negedge clk);
        check("rst rom_addr", 32'(rom_addr), 32'd0);
        check("rst pix_valid", 32'(pix_valid), 32'd0);
        check("rst pix_on", 32'(pix_on), 32'd0);
        check("rst dirty", 32'(dirty), 32'd0);
        rst = 1'b0;

        do_tick("reset code", 300, 230, 1'b1, 12'h400, 2'd0, 6'd0, 1'b1);

        wr(2'd0, 7'h41);
        check("dirty after wr0", 32'(dirty), 32'd1);
        do_tick("commit0", 0, 0, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        check("dirty after commit0", 32'(dirty), 32'd0);
        do_tick("slot0 A", 300, 230, 1'b1, 12'h820, 2'd0, 6'd0, 1'b1);

        rom_data = 8'h01;
        do_tick("corner", 331, 261, 1'b1, 12'h41F, 2'd3, 6'd31, 1'b1);
        do_tick("x past", 332, 261, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        do_tick("y past", 300, 262, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);

        rom_data = 8'h80;
        wr(2'd2, 7'h42);
        check("dirty wr2", 32'(dirty), 32'd1);
        do_tick("slot2 old", 316, 230, 1'b1, 12'h400, 2'd2, 6'd0, 1'b1);
        do_tick("commit2", 0, 0, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        check("dirty commit2", 32'(dirty), 32'd0);
        do_tick("slot2 new", 316, 230, 1'b1, 12'h840, 2'd2, 6'd0, 1'b1);

        // Write and commit tick in the same clock.
        @(negedge clk);
        wr(2'd3, 7'h44);
        @(negedge clk);
        pixel_x    = '0;
        pixel_y    = '0;
        pixel_tick = 1'b1;
        msg_we     = 1'b1;
        msg_idx    = 2'd1;
        msg_code   = 7'h43;
        @(negedge clk);
        pixel_tick = 1'b0;
        msg_we     = 1'b0;
        check("dirty same clk", 32'(dirty), 32'd1);
        repeat (3) @(negedge clk);
        do_tick("slot3 committed", 324, 230, 1'b1, 12'h880, 2'd3, 6'd0, 1'b1);
        do_tick("slot1 old", 308, 230, 1'b1, 12'h400, 2'd1, 6'd0, 1'b1);
        do_tick("commit1", 0, 0, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        check("dirty commit1", 32'(dirty), 32'd0);
        do_tick("slot1 new", 308, 230, 1'b1, 12'h860, 2'd1, 6'd0, 1'b1);

        rom_data = 8'h20;
        do_tick("mid cell", 310, 240, 1'b1, 12'h86A, 2'd1, 6'd10, 1'b1);
        rom_data = 8'hFF;
        do_tick("video off", 310, 240, 1'b0, 12'h000, 2'd0, 6'd0, 1'b0);
        do_tick("x below", 299, 240, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        do_tick("y below", 310, 229, 1'b1, 12'h000, 2'd0, 6'd0, 1'b0);
        do_tick("x first", 300, 240, 1'b1, 12'h82A, 2'd0, 6'd10, 1'b1);

        // Reset with a write pending and a tick in flight.
        wr(2'd0, 7'h55);
        @(negedge clk);
        pixel_x    = 10'd300;
        pixel_y    = 10'd230;
        pixel_tick = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst rom_addr", 32'(rom_addr), 32'd0);
        check("midrst dirty", 32'(dirty), 32'd0);
        check("midrst pix_on", 32'(pix_on), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst no valid", 32'(pix_valid), 32'd0);
        end
        do_tick("post rst slot0", 300, 230, 1'b1, 12'h400, 2'd0, 6'd0, 1'b1);
        do_tick("post rst slot1", 308, 230, 1'b1, 12'h400, 2'd1, 6'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
